// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: default widths, stack page base,
// store_kind encodings and the FSM state encoding.
package store_unit_pkg;

  localparam int          REG_WIDTH  = 8;
  localparam int          ADDR_WIDTH = 16;
  localparam logic [15:0] STACK_BASE = 16'h0100;

  // store_kind codes as seen on the request interface
  typedef enum logic [1:0] {
    KIND_BYTE   = 2'd0,  // one byte to an explicit address
    KIND_PUSH_B = 2'd1,  // push one byte onto the stack
    KIND_PUSH_W = 2'd2,  // push a word, high byte first
    KIND_RSVD   = 2'd3   // reserved, reported as an error
  } store_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/store_unit.sv
// Store unit: turns a single store request into one or two byte writes on
// the memory bus and, for pushes, reports the decremented stack pointer.
// Every output is driven straight from a flop.
module store_unit #(
  parameter int                    REG_WIDTH  = store_unit_pkg::REG_WIDTH,
  parameter int                    ADDR_WIDTH = store_unit_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = ADDR_WIDTH'(store_unit_pkg::STACK_BASE)
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  store_req,
  input  logic [1:0]            store_kind,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  input  logic [REG_WIDTH-1:0]  sp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_data,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  sp_next,
  output logic                  sp_we,
  output logic                  store_busy,
  output logic                  store_done,
  output logic                  store_err
);

  import store_unit_pkg::*;

  // Request captured at accept time; later input changes are ignored.
  store_kind_e           r_kind;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_data;
  logic [REG_WIDTH-1:0]  r_sp;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [REG_WIDTH-1:0]  r_mem_data;
  logic                  r_mem_we;
  logic [REG_WIDTH-1:0]  r_sp_next;
  logic                  r_sp_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  state_e                w_state_nxt;
  logic                  w_latch;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [REG_WIDTH-1:0]  w_mem_data_nxt;
  logic                  w_mem_we_nxt;
  logic [REG_WIDTH-1:0]  w_sp_next_nxt;
  logic                  w_sp_we_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic [REG_WIDTH-1:0]  w_sp_m1;
  logic [REG_WIDTH-1:0]  w_sp_m2;

  // SP arithmetic wraps within REG_WIDTH, so stack addresses stay in the page.
  assign w_sp_m1 = r_sp - REG_WIDTH'(1);
  assign w_sp_m2 = r_sp - REG_WIDTH'(2);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and next-output decode.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_mem_we_nxt   = 1'b0;
    w_sp_next_nxt  = r_sp_next;
    w_sp_we_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (store_req) begin
          w_latch = 1'b1;
          unique case (store_kind_e'(store_kind))
            KIND_BYTE: begin
              w_state_nxt    = ST_WR1;
              w_mem_we_nxt   = 1'b1;
              w_mem_addr_nxt = addr;
              w_mem_data_nxt = REG_WIDTH'(data_in[7:0]);
            end
            KIND_PUSH_B: begin
              w_state_nxt    = ST_WR1;
              w_mem_we_nxt   = 1'b1;
              w_mem_addr_nxt = STACK_BASE + ADDR_WIDTH'(sp);
              w_mem_data_nxt = REG_WIDTH'(data_in[7:0]);
            end
            KIND_PUSH_W: begin
              w_state_nxt    = ST_WR1;
              w_mem_we_nxt   = 1'b1;
              w_mem_addr_nxt = STACK_BASE + ADDR_WIDTH'(sp);
              w_mem_data_nxt = REG_WIDTH'(data_in[15:8]);
            end
            KIND_RSVD: begin
              w_state_nxt = ST_FIN;
            end
          endcase
        end
      end
      ST_WR1: begin
        if (r_kind == KIND_PUSH_W) begin
          // Low byte goes one slot below the high byte.
          w_state_nxt    = ST_WR2;
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = STACK_BASE + ADDR_WIDTH'(w_sp_m1);
          w_mem_data_nxt = REG_WIDTH'(r_data[7:0]);
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          if (r_kind == KIND_PUSH_B) begin
            w_sp_next_nxt = w_sp_m1;
            w_sp_we_nxt   = 1'b1;
          end
        end
      end
      ST_WR2: begin
        w_state_nxt   = ST_IDLE;
        w_done_nxt    = 1'b1;
        w_sp_next_nxt = w_sp_m2;
        w_sp_we_nxt   = 1'b1;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = 1'b1;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Request capture on the accept edge.
  // NOTE: these holding registers are reset too, so a reset mid-store leaves
  // no stale request behind.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_kind <= KIND_BYTE;
      r_addr <= '0;
      r_data <= '0;
      r_sp   <= '0;
    end else if (w_latch) begin
      r_kind <= store_kind_e'(store_kind);
      r_addr <= addr;
      r_data <= data_in;
      r_sp   <= sp;
    end
  end

  // Registered outputs.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_sp_next  <= '0;
      r_sp_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_sp_next  <= w_sp_next_nxt;
      r_sp_we    <= w_sp_we_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_we     = r_mem_we;
  assign sp_next    = r_sp_next;
  assign sp_we      = r_sp_we;
  assign store_busy = r_busy;
  assign store_done = r_done;
  assign store_err  = r_err;

  // The BYTE target address is consumed at accept time; the captured copy is
  // kept for debug visibility only.
  logic w_unused;
  assign w_unused = ^r_addr;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: table of single requests plus
// hand-written busy, back-to-back and reset-abort sequences.
module tb_store_unit;

  logic        phi1;
  logic        reset_n;
  logic        store_req;
  logic [1:0]  store_kind;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [7:0]  sp;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [7:0]  sp_next;
  logic        sp_we;
  logic        store_busy;
  logic        store_done;
  logic        store_err;

  int n_checks = 0;
  int n_errors = 0;

  store_unit dut (
    .phi1       (phi1),
    .reset_n    (reset_n),
    .store_req  (store_req),
    .store_kind (store_kind),
    .addr       (addr),
    .data_in    (data_in),
    .sp         (sp),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .sp_next    (sp_next),
    .sp_we      (sp_we),
    .store_busy (store_busy),
    .store_done (store_done),
    .store_err  (store_err)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  sp;
    int          n_wr;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
    logic        sp_we;
    logic [7:0]  sp_next;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  32'(mem_addr),   32'h0);
    check({tag, "_data"},  32'(mem_data),   32'h0);
    check({tag, "_we"},    32'(mem_we),     32'h0);
    check({tag, "_spn"},   32'(sp_next),    32'h0);
    check({tag, "_spwe"},  32'(sp_we),      32'h0);
    check({tag, "_busy"},  32'(store_busy), 32'h0);
    check({tag, "_done"},  32'(store_done), 32'h0);
    check({tag, "_err"},   32'(store_err),  32'h0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"},   32'(mem_we),     32'h0);
    check({tag, "_spwe"}, 32'(sp_we),      32'h0);
    check({tag, "_busy"}, 32'(store_busy), 32'h0);
    check({tag, "_done"}, 32'(store_done), 32'h0);
    check({tag, "_err"},  32'(store_err),  32'h0);
  endtask

  task automatic check_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    check({tag, "_we"},   32'(mem_we),     32'h1);
    check({tag, "_addr"}, 32'(mem_addr),   32'(a));
    check({tag, "_data"}, 32'(mem_data),   32'(d));
    check({tag, "_busy"}, 32'(store_busy), 32'h1);
    check({tag, "_done"}, 32'(store_done), 32'h0);
  endtask

  task automatic request(input logic [1:0] k, input logic [15:0] a,
                         input logic [15:0] d, input logic [7:0] s);
    store_req  = 1'b1;
    store_kind = k;
    addr       = a;
    data_in    = d;
    sp         = s;
  endtask

  initial begin
    //            kind  addr      data      sp     n  a0        d0     a1        d1     spwe  spn    err
    vecs[0] = '{2'd0, 16'h0200, 16'h005A, 8'h33, 1, 16'h0200, 8'h5A, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{2'd2, 16'h0000, 16'h1234, 8'hFD, 2, 16'h01FD, 8'h12, 16'h01FC, 8'h34, 1'b1, 8'hFB, 1'b0};
    vecs[2] = '{2'd2, 16'h0000, 16'hABCD, 8'h00, 2, 16'h0100, 8'hAB, 16'h01FF, 8'hCD, 1'b1, 8'hFE, 1'b0};
    vecs[3] = '{2'd1, 16'h0000, 16'h00C3, 8'h80, 1, 16'h0180, 8'hC3, 16'h0000, 8'h00, 1'b1, 8'h7F, 1'b0};
    vecs[4] = '{2'd1, 16'h0555, 16'hEE11, 8'h00, 1, 16'h0100, 8'h11, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{2'd3, 16'h1234, 16'h9999, 8'h10, 0, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{2'd0, 16'hFFFF, 16'h12A5, 8'h44, 1, 16'hFFFF, 8'hA5, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{2'd2, 16'h0000, 16'h0F1E, 8'h01, 2, 16'h0101, 8'h0F, 16'h0100, 8'h1E, 1'b1, 8'hFF, 1'b0};

    reset_n    = 1'b0;
    store_req  = 1'b0;
    store_kind = 2'd0;
    addr       = 16'h0;
    data_in    = 16'h0;
    sp         = 8'h0;
    #12;
    check_zero("rst_async");
    tick();
    check_zero("rst_held");

    // Release reset away from the edge; the first vector is offered at once
    // so it must be taken on the very next posedge.
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      int nb;
      nb = (vecs[i].n_wr > 1) ? vecs[i].n_wr : 1;
      request(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].sp);
      tick();
      store_req = 1'b0;
      for (int c = 0; c < nb; c++) begin
        if (c < vecs[i].n_wr) begin
          check_write($sformatf("v%0d_c%0d", i, c),
                      (c == 0) ? vecs[i].a0 : vecs[i].a1,
                      (c == 0) ? vecs[i].d0 : vecs[i].d1);
        end else begin
          check($sformatf("v%0d_c%0d_we", i, c),   32'(mem_we),     32'h0);
          check($sformatf("v%0d_c%0d_busy", i, c), 32'(store_busy), 32'h1);
          check($sformatf("v%0d_c%0d_done", i, c), 32'(store_done), 32'h0);
        end
        tick();
      end
      check($sformatf("v%0d_done", i),      32'(store_done), 32'h1);
      check($sformatf("v%0d_done_we", i),   32'(mem_we),     32'h0);
      check($sformatf("v%0d_done_busy", i), 32'(store_busy), 32'h0);
      check($sformatf("v%0d_err", i),       32'(store_err),  32'(vecs[i].err));
      check($sformatf("v%0d_spwe", i),      32'(sp_we),      32'(vecs[i].sp_we));
      if (vecs[i].sp_we)
        check($sformatf("v%0d_spn", i), 32'(sp_next), 32'(vecs[i].sp_next));
      tick();
      check_quiet($sformatf("v%0d_after", i));
    end

    // Busy: a request in WR1 (with all inputs changed) must be ignored.
    request(2'd2, 16'h0000, 16'hBEEF, 8'h40);
    tick();
    check_write("busy_wr1", 16'h0140, 8'hBE);
    request(2'd0, 16'h0300, 16'h0077, 8'h10);
    tick();
    check_write("busy_wr2", 16'h013F, 8'hEF);
    store_req = 1'b0;
    tick();
    check("busy_done",  32'(store_done), 32'h1);
    check("busy_spwe",  32'(sp_we),      32'h1);
    check("busy_spn",   32'(sp_next),    32'h3E);
    // Back-to-back: a request during the done cycle is taken immediately.
    request(2'd0, 16'h0300, 16'h0077, 8'h10);
    tick();
    store_req = 1'b0;
    check_write("b2b_wr1", 16'h0300, 8'h77);
    tick();
    check("b2b_done", 32'(store_done), 32'h1);
    check("b2b_spwe", 32'(sp_we),      32'h0);
    tick();
    check_quiet("b2b_after");

    // Reset after the first word-push write aborts the store.
    request(2'd2, 16'h0000, 16'h5566, 8'h20);
    tick();
    store_req = 1'b0;
    check_write("abort_wr1", 16'h0120, 8'h55);
    #1 reset_n = 1'b0;
    #1;
    check_zero("abort_rst");
    reset_n = 1'b1;
    tick();
    check_zero("abort_c1");
    tick();
    check_zero("abort_c2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter REG_WIDTH, default 8, data byte width.
REQ-002 Parameter ADDR_WIDTH, default 16, bus address width.
REQ-003 Parameter STACK_BASE, default 16'h0100, base address of the stack page.
REQ-004 phi1  in  1  sole clock; all state updates on posedge phi1.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 store_req  in  1  write request, sampled only in IDLE.
REQ-007 store_kind  in  2  0 = BYTE to addr, 1 = PUSH byte, 2 = PUSH word, 3 = reserved.
REQ-008 addr  in  ADDR_WIDTH  target address for BYTE kind.
REQ-009 data_in  in  16  write data; byte kinds use [7:0], word uses [15:8] high and [7:0] low.
REQ-010 sp  in  REG_WIDTH  current stack pointer.
REQ-011 mem_addr  out  ADDR_WIDTH  memory write address.
REQ-012 mem_data  out  REG_WIDTH  memory write data.
REQ-013 mem_we  out  1  memory write strobe, one byte per cycle.
REQ-014 sp_next  out  REG_WIDTH  updated stack pointer.
REQ-015 sp_we  out  1  one-cycle strobe validating sp_next.
REQ-016 store_busy  out  1  high in every non-IDLE state.
REQ-017 store_done  out  1  one-cycle completion pulse.
REQ-018 store_err  out  1  one-cycle pulse for reserved kind, coincident with store_done.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE, WR1, WR2, FIN.
REQ-021 IDLE with store_req=1 SHALL latch kind, addr, data_in and sp; later input changes SHALL have no effect.
REQ-022 BYTE: the edge that accepts the request SHALL enter WR1 with mem_we=1, mem_addr=addr, mem_data=data_in[7:0]. The next edge SHALL go to IDLE with mem_we=0 and store_done=1.
REQ-023 PUSH byte: same as BYTE with mem_addr=STACK_BASE+sp. The completing edge SHALL also set sp_next=sp-1 and sp_we=1.
REQ-024 PUSH word: the accept edge SHALL enter WR1 writing data_in[15:8] to STACK_BASE+sp. The next edge SHALL enter WR2 writing data_in[7:0] to STACK_BASE+((sp-1) mod 256). The next edge SHALL go to IDLE with mem_we=0, store_done=1, sp_next=sp-2, sp_we=1.
REQ-025 Reserved kind: the accept edge SHALL enter FIN with no write. The next edge SHALL go to IDLE with store_done=1 and store_err=1.
REQ-026 SP arithmetic SHALL be mod 256; stack addresses SHALL never leave the stack page.
REQ-027 store_req while busy SHALL be ignored, with no queuing.
REQ-028 A store_req present in the cycle store_done is high SHALL be accepted, since the FSM is already in IDLE (back-to-back, no bubble).
REQ-029 mem_we SHALL never be high in IDLE or FIN.
REQ-030 store_done, sp_we and store_err SHALL each be high for exactly one cycle per request.

Reset
REQ-031 reset_n low SHALL force IDLE immediately and zero all outputs, including mem_addr, mem_data and sp_next.
REQ-032 Reset mid-operation SHALL abort the store: no further mem_we, no sp_we, no store_done.
REQ-033 The first request SHALL be accepted at the first posedge phi1 after reset_n is released.

Structure
REQ-034 The shared package SHALL hold REG_WIDTH, ADDR_WIDTH, STACK_BASE, the store_kind codes and the FSM state encoding.
REQ-035 The block SHALL be a single module with no sub-module; stack address formation SHALL be inline.

Verification
REQ-036 BYTE: addr=16'h0200, data_in=16'h005A -> one cycle mem_we=1 @0x0200 data 0x5A; done on the next cycle; sp_we=0.
REQ-037 PUSH word: sp=0xFD, data_in=16'h1234 -> 0x12 @0x01FD, then 0x34 @0x01FC; done with sp_next=0xFB, sp_we=1.
REQ-038 Wrap: PUSH word with sp=0x00 -> writes @0x0100 then @0x01FF; sp_next=0xFE.
REQ-039 Busy/back-to-back: second request during WR1 is ignored; a request during the done cycle is accepted with mem_we=1 in the following cycle.
REQ-040 Reset after the first PUSH word write -> outputs 0 immediately; no second write; no sp_we or done.
REQ-041 Reserved kind=3 -> no mem_we; store_done=1 and store_err=1 together, two cycles after the request.
